// File: rtl/wbcon_mreq_arb_if.sv
// One MREQ command link plus its Rx (write-data) and Tx (read-data) byte streams.
// master drives the request and write bytes; slave completes it and returns read bytes.
interface wbcon_mreq_arb_if #(
    parameter int COUNT_WIDTH   = 8,
    parameter int WB_ADDR_WIDTH = 24
) ();
    logic                     mreq_valid;
    logic                     mreq_ready;
    logic [WB_ADDR_WIDTH-1:0] mreq_addr;
    logic [COUNT_WIDTH-1:0]   mreq_cnt;
    logic                     mreq_wr;
    logic                     mreq_aincr;
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     rx_ready;
    logic                     tx_valid;
    logic [7:0]               tx_data;
    logic                     tx_ready;

    modport master (
        output mreq_valid, mreq_addr, mreq_cnt, mreq_wr, mreq_aincr,
        output rx_valid, rx_data, tx_ready,
        input  mreq_ready, rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  mreq_valid, mreq_addr, mreq_cnt, mreq_wr, mreq_aincr,
        input  rx_valid, rx_data, tx_ready,
        output mreq_ready, rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/wbcon_mreq_arb.sv
// Two-requester arbiter in front of the Wishbone MREQ executor; the grant is held for a whole request.
// Define WBCON_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins), otherwise round-robin.
module wbcon_mreq_arb #(
    parameter int COUNT_WIDTH   = 8,
    parameter int WB_ADDR_WIDTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    wbcon_mreq_arb_if.slave   s0,
    wbcon_mreq_arb_if.slave   s1,
    wbcon_mreq_arb_if.master  m,
    output logic              o_busy,
    output logic              o_grant
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic   grant_reg, grant_next;
    logic   winner;
`ifndef WBCON_ARB_FIXED_PRIO_EN
    logic   last_reg, last_next;
`endif

    logic [1:0]               s_mreq_valid;
    logic [WB_ADDR_WIDTH-1:0] s_mreq_addr  [2];
    logic [COUNT_WIDTH-1:0]   s_mreq_cnt   [2];
    logic [1:0]               s_mreq_wr;
    logic [1:0]               s_mreq_aincr;
    logic [1:0]               s_rx_valid;
    logic [7:0]               s_rx_data    [2];
    logic [1:0]               s_tx_ready;
    logic [1:0]               s_mreq_ready;
    logic [1:0]               s_rx_ready;
    logic [1:0]               s_tx_valid;
    logic [1:0]               sel;
    logic                     busy;

    // Gather both requesters into arrays so the per-port logic can be generated.
    assign s_mreq_valid    = {s1.mreq_valid, s0.mreq_valid};
    assign s_mreq_addr[0]  = s0.mreq_addr;
    assign s_mreq_addr[1]  = s1.mreq_addr;
    assign s_mreq_cnt[0]   = s0.mreq_cnt;
    assign s_mreq_cnt[1]   = s1.mreq_cnt;
    assign s_mreq_wr       = {s1.mreq_wr, s0.mreq_wr};
    assign s_mreq_aincr    = {s1.mreq_aincr, s0.mreq_aincr};
    assign s_rx_valid      = {s1.rx_valid, s0.rx_valid};
    assign s_rx_data[0]    = s0.rx_data;
    assign s_rx_data[1]    = s1.rx_data;
    assign s_tx_ready      = {s1.tx_ready, s0.tx_ready};

    always_comb begin
`ifdef WBCON_ARB_FIXED_PRIO_EN
        winner = ~s_mreq_valid[0];
`else
        // Both requesting: the port that did not win last time; otherwise the only requester.
        winner = (&s_mreq_valid) ? ~last_reg : ~s_mreq_valid[0];
`endif
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
`ifndef WBCON_ARB_FIXED_PRIO_EN
        last_next  = last_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (|s_mreq_valid) begin
                    grant_next = winner;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Grant is released only by the executor's completion pulse.
                if (m.mreq_ready) begin
                    state_next = ST_IDLE;
`ifndef WBCON_ARB_FIXED_PRIO_EN
                    last_next  = grant_reg;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            grant_reg <= 1'b0;
`ifndef WBCON_ARB_FIXED_PRIO_EN
            last_reg  <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
`ifndef WBCON_ARB_FIXED_PRIO_EN
            last_reg  <= last_next;
`endif
        end
    end

    assign busy    = (state_reg == ST_BUSY);
    assign o_busy  = busy;
    assign o_grant = grant_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign sel[gi]          = busy && (grant_reg == gi[0]);
            assign s_mreq_ready[gi] = sel[gi] & m.mreq_ready;
            assign s_rx_ready[gi]   = sel[gi] & m.rx_ready;
            assign s_tx_valid[gi]   = sel[gi] & m.tx_valid;
        end
    endgenerate

    assign s0.mreq_ready = s_mreq_ready[0];
    assign s1.mreq_ready = s_mreq_ready[1];
    assign s0.rx_ready   = s_rx_ready[0];
    assign s1.rx_ready   = s_rx_ready[1];
    assign s0.tx_valid   = s_tx_valid[0];
    assign s1.tx_valid   = s_tx_valid[1];
    // Read bytes fan out to both ports; tx_valid alone qualifies them.
    assign s0.tx_data    = m.tx_data;
    assign s1.tx_data    = m.tx_data;

    assign m.mreq_valid = busy & s_mreq_valid[grant_reg];
    assign m.mreq_addr  = busy ? s_mreq_addr[grant_reg] : '0;
    assign m.mreq_cnt   = busy ? s_mreq_cnt[grant_reg]  : '0;
    assign m.mreq_wr    = busy & s_mreq_wr[grant_reg];
    assign m.mreq_aincr = busy & s_mreq_aincr[grant_reg];
    assign m.rx_valid   = busy & s_rx_valid[grant_reg];
    assign m.rx_data    = busy ? s_rx_data[grant_reg] : 8'h00;
    assign m.tx_ready   = busy & s_tx_ready[grant_reg];

endmodule

// File: tb/tb_wbcon_mreq_arb.sv
// Randomized directed bench for wbcon_mreq_arb against a request-level arbitration model.
module tb_wbcon_mreq_arb;

    logic clk;
    logic rst_n;
    logic busy;
    logic grant;

    wbcon_mreq_arb_if #(.COUNT_WIDTH(8), .WB_ADDR_WIDTH(24)) s0_if ();
    wbcon_mreq_arb_if #(.COUNT_WIDTH(8), .WB_ADDR_WIDTH(24)) s1_if ();
    wbcon_mreq_arb_if #(.COUNT_WIDTH(8), .WB_ADDR_WIDTH(24)) m_if ();

    wbcon_mreq_arb #(.COUNT_WIDTH(8), .WB_ADDR_WIDTH(24)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .o_busy  (busy),
        .o_grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending requests with their fields, and the last winner.
    bit          pending [2];
    logic [23:0] f_addr  [2];
    logic [7:0]  f_cnt   [2];
    logic        f_wr    [2];
    logic        f_aincr [2];
    int          exp_last;
    int          n_txn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_mready(input int k);
        return (k == 0) ? s0_if.mreq_ready : s1_if.mreq_ready;
    endfunction
    function automatic logic get_rx_ready(input int k);
        return (k == 0) ? s0_if.rx_ready : s1_if.rx_ready;
    endfunction
    function automatic logic get_tx_valid(input int k);
        return (k == 0) ? s0_if.tx_valid : s1_if.tx_valid;
    endfunction
    function automatic logic [7:0] get_tx_data(input int k);
        return (k == 0) ? s0_if.tx_data : s1_if.tx_data;
    endfunction

    task automatic drive_req(input int k);
        if (k == 0) begin
            s0_if.mreq_valid = pending[0];
            s0_if.mreq_addr  = f_addr[0];
            s0_if.mreq_cnt   = f_cnt[0];
            s0_if.mreq_wr    = f_wr[0];
            s0_if.mreq_aincr = f_aincr[0];
        end else begin
            s1_if.mreq_valid = pending[1];
            s1_if.mreq_addr  = f_addr[1];
            s1_if.mreq_cnt   = f_cnt[1];
            s1_if.mreq_wr    = f_wr[1];
            s1_if.mreq_aincr = f_aincr[1];
        end
    endtask

    task automatic set_rx(input int k, input logic v, input logic [7:0] d);
        if (k == 0) begin s0_if.rx_valid = v; s0_if.rx_data = d; end
        else        begin s1_if.rx_valid = v; s1_if.rx_data = d; end
    endtask

    task automatic set_tx_ready(input int k, input logic r);
        if (k == 0) s0_if.tx_ready = r;
        else        s1_if.tx_ready = r;
    endtask

    task automatic clear_streams();
        set_rx(0, 1'b0, 8'h00);
        set_rx(1, 1'b0, 8'h00);
        set_tx_ready(0, 1'b0);
        set_tx_ready(1, 1'b0);
        m_if.rx_ready = 1'b0;
        m_if.tx_valid = 1'b0;
        m_if.tx_data  = 8'h00;
    endtask

    // Called in the low phase of an idle cycle; runs one full request and returns in the next idle cycle.
    task automatic do_txn(input logic [1:0] newreq);
        int w, o, nb, it;
        logic [7:0] b;
        logic rdy;
        for (int k = 0; k < 2; k++) begin
            if (newreq[k] && !pending[k]) begin
                f_addr[k]  = 24'($urandom);
                f_cnt[k]   = 8'($urandom_range(0, 3));
                f_wr[k]    = 1'($urandom);
                f_aincr[k] = 1'($urandom);
                pending[k] = 1'b1;
            end
        end
        drive_req(0);
        drive_req(1);
        if (!pending[0] && !pending[1]) return;
`ifdef WBCON_ARB_FIXED_PRIO_EN
        w = pending[0] ? 0 : 1;
`else
        w = (pending[0] && pending[1]) ? 1 - exp_last : (pending[0] ? 0 : 1);
`endif
        o = 1 - w;
        n_txn++;
        $display("txn %0d: pend=%0d%0d grant=%0d wr=%0d addr=%06h cnt=%0d",
                 n_txn, pending[1], pending[0], w, f_wr[w], f_addr[w], f_cnt[w]);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("busy_on_grant", 32'(busy), 32'd1);
        chk("grant_idx", 32'(grant), 32'(w));
        chk("m_mreq_valid", 32'(m_if.mreq_valid), 32'd1);
        chk("m_mreq_addr", 32'(m_if.mreq_addr), 32'(f_addr[w]));
        chk("m_mreq_cnt", 32'(m_if.mreq_cnt), 32'(f_cnt[w]));
        chk("m_mreq_wr", 32'(m_if.mreq_wr), 32'(f_wr[w]));
        chk("m_mreq_aincr", 32'(m_if.mreq_aincr), 32'(f_aincr[w]));
        chk("other_mready", 32'(get_mready(o)), 32'd0);

        nb = int'(f_cnt[w]) + 1;
        it = 0;
        b  = 8'($urandom);
        while (nb > 0 && it < 64) begin
            it++;
            rdy = ($urandom_range(0, 2) != 0);
            if (f_wr[w]) begin
                set_rx(w, 1'b1, b);
                set_rx(o, 1'b1, 8'hFF);
                m_if.rx_ready = rdy;
                #1;
                chk("m_rx_valid", 32'(m_if.rx_valid), 32'd1);
                chk("m_rx_data", 32'(m_if.rx_data), 32'(b));
                chk("grant_rx_ready", 32'(get_rx_ready(w)), 32'(rdy));
                chk("other_rx_ready", 32'(get_rx_ready(o)), 32'd0);
            end else begin
                m_if.tx_valid = 1'b1;
                m_if.tx_data  = b;
                set_tx_ready(w, rdy);
                set_tx_ready(o, 1'b1);
                #1;
                chk("grant_tx_valid", 32'(get_tx_valid(w)), 32'd1);
                chk("grant_tx_data", 32'(get_tx_data(w)), 32'(b));
                chk("other_tx_valid", 32'(get_tx_valid(o)), 32'd0);
                chk("m_tx_ready", 32'(m_if.tx_ready), 32'(rdy));
            end
            @(posedge clk);
            if (rdy) begin
                nb--;
                b = 8'($urandom);
            end
            @(negedge clk);
        end
        chk("stream_done", 32'(nb), 32'd0);

        clear_streams();
        m_if.mreq_ready = 1'b1;
        #1;
        chk("grant_mready", 32'(get_mready(w)), 32'd1);
        chk("other_mready_cpl", 32'(get_mready(o)), 32'd0);
        chk("busy_at_cpl", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        m_if.mreq_ready = 1'b0;
        pending[w] = 1'b0;
        drive_req(w);
        exp_last = w;
        #1;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("m_valid_idle", 32'(m_if.mreq_valid), 32'd0);
        chk("m_addr_idle", 32'(m_if.mreq_addr), 32'd0);
        chk("grant_kept", 32'(grant), 32'(w));
        chk("mready_idle", 32'(get_mready(w)), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_if.mreq_valid), 32'd0);
        chk({tag, "_m_addr"}, 32'(m_if.mreq_addr), 32'd0);
        chk({tag, "_m_cnt"}, 32'(m_if.mreq_cnt), 32'd0);
        chk({tag, "_m_rx_valid"}, 32'(m_if.rx_valid), 32'd0);
        chk({tag, "_m_rx_data"}, 32'(m_if.rx_data), 32'd0);
        chk({tag, "_m_tx_ready"}, 32'(m_if.tx_ready), 32'd0);
        chk({tag, "_s0_rx_ready"}, 32'(s0_if.rx_ready), 32'd0);
        chk({tag, "_s0_mready"}, 32'(s0_if.mreq_ready), 32'd0);
        chk({tag, "_s1_tx_valid"}, 32'(s1_if.tx_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            pending[k] = 1'b0; f_addr[k] = '0; f_cnt[k] = '0; f_wr[k] = 1'b0; f_aincr[k] = 1'b0;
        end
        drive_req(0);
        drive_req(1);
        clear_streams();
        m_if.mreq_ready = 1'b0;
        m_if.rx_ready   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1;

        // Single write on s0.
        f_addr[0] = 24'h000010; f_cnt[0] = 8'd3; f_wr[0] = 1'b1; f_aincr[0] = 1'b1;
        pending[0] = 1'b1;
        do_txn(2'b00);

        // Simultaneous requests, then the leftover one.
        do_txn(2'b11);
        do_txn(2'b01);
        do_txn(2'b00);

        // Both requesting continuously.
        repeat (6) do_txn(2'b11);

        // Random request patterns.
        repeat (40) do_txn(2'($urandom_range(1, 3)));
        while (pending[0] || pending[1]) do_txn(2'b00);

        // Reset in the middle of a write stream.
        f_addr[0] = 24'h00ABCD; f_cnt[0] = 8'd3; f_wr[0] = 1'b1; f_aincr[0] = 1'b0;
        pending[0] = 1'b1;
        drive_req(0);
        @(posedge clk);
        @(negedge clk);
        set_rx(0, 1'b1, 8'h3C);
        m_if.rx_ready = 1'b1;
        #1;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        $display("txn reset: asserted mid-stream");
        clear_streams();
        pending[0] = 1'b0;
        drive_req(0);
        exp_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(2'b11);
        do_txn(2'b00);
        repeat (4) do_txn(2'($urandom_range(1, 3)));
        while (pending[0] || pending[1]) do_txn(2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wbcon_mreq_arb.md
# wbcon_mreq_arb

Two-port arbiter that shares a single Wishbone command executor (the MREQ + Rx/Tx byte-stream engine) between two requesters, e.g. the USB command channel and an internal sequencer. It selects one requester, holds the grant for the entire memory request, including all of its data bytes, and routes that requester's MREQ fields and byte streams to the executor. It sits directly in front of the executor; the executor's Wishbone side is untouched.

## Interface
- `COUNT_WIDTH`, 8, MREQ word-count width (matches executor)
- `WB_ADDR_WIDTH`, 24, MREQ word-address width (matches executor)

Ports, with `k` ∈ {0,1} for the per-requester groups:
- `i_clk` in 1: clock, posedge
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_sk_mreq_valid` in 1 / `o_sk_mreq_ready` out 1: requester k MREQ handshake
- `i_sk_mreq_addr` in WB_ADDR_WIDTH, `i_sk_mreq_cnt` in COUNT_WIDTH, `i_sk_mreq_wr` in 1, `i_sk_mreq_aincr` in 1: requester k MREQ fields
- `i_sk_rx_valid` in 1, `i_sk_rx_data` in 8, `o_sk_rx_ready` out 1: requester k write-data stream
- `o_sk_tx_valid` out 1, `o_sk_tx_data` out 8, `i_sk_tx_ready` in 1: requester k read-data stream
- `o_m_mreq_valid` out 1 / `i_m_mreq_ready` in 1: to executor
- `o_m_mreq_addr` out WB_ADDR_WIDTH, `o_m_mreq_cnt` out COUNT_WIDTH, `o_m_mreq_wr` out 1, `o_m_mreq_aincr` out 1: to executor
- `o_m_rx_valid` out 1, `o_m_rx_data` out 8, `i_m_rx_ready` in 1: to executor
- `i_m_tx_valid` in 1, `i_m_tx_data` in 8, `o_m_tx_ready` out 1: from executor
- `o_busy` out 1: a grant is active
- `o_grant` out 1: index of the granted/last-granted port

## Operation
- **MREQ handshake semantics (executor's):** the requester holds valid and all fields stable until ready. Ready is a single-cycle pulse issued at request **completion**, not at acceptance.
- **FSM states:**
  - ST_IDLE: `o_m_mreq_valid`=0. If any `i_sk_mreq_valid`=1, register the winner into `grant` and go to ST_BUSY.
  - ST_BUSY: mux the granted port onto the master and hold the grant unconditionally. On `i_m_mreq_ready`=1, go to ST_IDLE and set `last` = `grant`.
- **Arbitration:** round-robin. With both valid, the port ≠ `last` wins. With one valid, that port wins.
- **Muxing in ST_BUSY:**
  - MREQ fields and `o_m_mreq_valid` come from `i_s<grant>_*`.
  - `o_s<grant>_mreq_ready` = `i_m_mreq_ready`.
  - `o_m_rx_valid`/`o_m_rx_data` come from granted port rx; `o_s<grant>_rx_ready` = `i_m_rx_ready`.
  - `o_s<grant>_tx_valid` = `i_m_tx_valid`; `o_m_tx_ready` = `i_s<grant>_tx_ready`.
- **Non-granted port, and both ports in ST_IDLE:**
  - mreq_ready=0, rx_ready=0, tx_valid=0.
  - `o_m_rx_valid`=0; `o_m_tx_ready`=0.
  - Master MREQ fields are driven to 0.
- **Tx data:** `o_sk_tx_data` = `i_m_tx_data` on both ports; gated only by valid.
- **Requester drops valid while granted:** this is a protocol violation. The grant is still held until `i_m_mreq_ready`; no recovery is attempted.
- **Reset values:** state ST_IDLE, `grant`=0, `last`=1 (port 0 wins first), `o_busy`=0, `o_grant`=0. All valid/ready outputs are 0 and all data outputs are 0.

## Timing
- **Grant latency:** valid high at edge N in ST_IDLE → ST_BUSY after edge N; `o_m_mreq_valid` goes high combinationally in the cycle after N.
- **Completion:** the `i_m_mreq_ready` pulse passes combinationally to the granted requester in the same cycle. The state returns to ST_IDLE at the next edge.
- **Back-to-back requests:** at least one ST_IDLE cycle separates consecutive grants. This matches the executor's mandatory idle cycle.
- **Simultaneous completion and new request:** a completion on port k while the other port is valid grants the other port at the next decision, one idle cycle later.
- **Combinational paths:** no added latency on stream handshakes; all paths are combinational through the mux, which is keyed only on the registered `grant` and state.
- **Asynchronous reset mid-request:** outputs clear immediately. The executor must be reset in the same domain.

## Configuration
- `WBCON_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; port 0 always wins when both are valid. `last` is not implemented; `o_grant` still reports the current or last grant.
  - Undefined: round-robin as described in Operation.

## Test plan
- Only s0 valid, addr=0x000010, cnt=3, wr=1, executor ack after 4 words → s0 receives a one-cycle ready, `o_busy` falls one cycle later, and s1 outputs stay 0 throughout.
- s0 and s1 valid in the same cycle after reset → s0 granted first; after its completion and one idle cycle, s1 granted. With `WBCON_ARB_FIXED_PRIO_EN` and s0 re-requesting, s0 wins again.
- s1 read granted, executor emits tx bytes 0xA5, 0x5A while s1 tx_ready toggles → bytes reach s1 in order with stalls respected, and `o_s0_tx_valid` stays 0.
- s0 write granted; s1 asserts rx_valid with data 0xFF during the grant → `o_s1_rx_ready` stays 0 and only s0 bytes appear on `o_m_rx_data`.
- Both valid continuously for 6 transactions, round-robin build → grant sequence 0,1,0,1,0,1, with exactly one idle cycle between each.
- `i_rst_n` asserted in ST_BUSY mid-stream → all outputs 0 immediately; after release, the first grant goes to port 0.
